// File: rtl/cpu_rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// pkg_cpu_typedefs
// Shared types for the register-file write-back arbiter.
//   RF_ADDR_W / RF_DATA_W : default register-bank geometry (32 x 32 bit)
//   gnt_sel_e             : which requester owns the write port this cycle
//   wr_req_t              : one write request (valid, addr, data)
//   other_req()           : the requester that is not the argument
// The optional round-robin arbitration is enabled by CPU_RF_WB_ARB_RR_EN.
// ----------------------------------------------------------------------------
package pkg_cpu_typedefs;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } gnt_sel_e;

    // Sized for the default bank geometry.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

    function automatic gnt_sel_e other_req(input gnt_sel_e g);
        return (g == GNT_REQ0) ? GNT_REQ1 : GNT_REQ0;
    endfunction

endpackage

// File: rtl/cpu_rf_wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// cpu_rf_scoreboard
// Tracks registers that have an outstanding load-unit write.
//   clk_i, rst_ni          : clock, async active-low reset
//   set_v_i / set_addr_i   : mark a destination pending (x0 ignored)
//   clr_v_i / clr_addr_i   : retire a pending destination
//   rs1_i / rs2_i          : read addresses to look up
//   haz1_o / haz2_o        : combinational pending lookup for rs1 / rs2
//   pend_mask_o            : one bit per register, registered
// ----------------------------------------------------------------------------
module cpu_rf_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       set_v_i,
    input  logic [ADDR_WIDTH-1:0]      set_addr_i,
    input  logic                       clr_v_i,
    input  logic [ADDR_WIDTH-1:0]      clr_addr_i,
    input  logic [ADDR_WIDTH-1:0]      rs1_i,
    input  logic [ADDR_WIDTH-1:0]      rs2_i,
    output logic                       haz1_o,
    output logic                       haz2_o,
    output logic [(2**ADDR_WIDTH)-1:0] pend_mask_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] set_1h, clr_1h;

    // Clear is applied before set so a same-cycle set/clear of one bit
    // leaves it pending (the new issue is younger than the retiring write).
    always_comb begin
        set_1h = '0;
        clr_1h = '0;
        if (set_v_i && (set_addr_i != '0)) set_1h[set_addr_i] = 1'b1;
        if (clr_v_i)                       clr_1h[clr_addr_i] = 1'b1;
        pend_d = (pend_q & ~clr_1h) | set_1h;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign haz1_o      = (rs1_i != '0) && pend_q[rs1_i];
    assign haz2_o      = (rs2_i != '0) && pend_q[rs2_i];
    assign pend_mask_o = pend_q;

endmodule

// File: rtl/cpu_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_rf_wb_arbiter
// Arbitrates two write-back requesters onto one registered register-bank
// write port and tracks pending load-unit destinations.
//   clk, rst_n                 : clock, async active-low reset
//   req0_*                     : execute-pipe write request (v/rdy/addr/data)
//   req1_*                     : load/multicycle-unit write request
//   stall                      : blocks all grants
//   iss_v / iss_addr           : load issue, marks destination pending
//   rs1 / rs2, haz1 / haz2     : pending-write hazard lookup
//   pend_mask                  : outstanding load-unit writes
//   wen3 / a3 / wd3            : registered bank write port
// Build option CPU_RF_WB_ARB_RR_EN: round-robin between requesters when both
// are valid; otherwise requester 0 has fixed priority.
//
// Handshake: a transfer on requester i happens in a cycle where reqi_v and
// reqi_rdy are both high. rdy is combinational, never high without v, and at
// most one rdy is high per cycle. Requesters must hold v/addr/data until the
// transfer.
// ----------------------------------------------------------------------------
module cpu_rf_wb_arbiter
    import pkg_cpu_typedefs::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_v,
    output logic                       req0_rdy,
    input  logic [ADDR_WIDTH-1:0]      req0_addr,
    input  logic [DATA_WIDTH-1:0]      req0_data,
    input  logic                       req1_v,
    output logic                       req1_rdy,
    input  logic [ADDR_WIDTH-1:0]      req1_addr,
    input  logic [DATA_WIDTH-1:0]      req1_data,
    input  logic                       stall,
    input  logic                       iss_v,
    input  logic [ADDR_WIDTH-1:0]      iss_addr,
    input  logic [ADDR_WIDTH-1:0]      rs1,
    input  logic [ADDR_WIDTH-1:0]      rs2,
    output logic                       haz1,
    output logic                       haz2,
    output logic [(2**ADDR_WIDTH)-1:0] pend_mask,
    output logic                       wen3,
    output logic [ADDR_WIDTH-1:0]      a3,
    output logic [DATA_WIDTH-1:0]      wd3
);

    gnt_sel_e gnt;
    gnt_sel_e both_sel;   // winner when both requesters are valid
    logic     hs0, hs1;
    wr_req_t  sel_req;

    logic                  wen3_q, wen3_d;
    logic [ADDR_WIDTH-1:0] a3_q,   a3_d;
    logic [DATA_WIDTH-1:0] wd3_q,  wd3_d;

`ifdef CPU_RF_WB_ARB_RR_EN
    gnt_sel_e ptr_q, ptr_d;

    // Pointer moves to the other requester only on an actual transfer, so a
    // stalled or idle cycle never changes fairness.
    always_comb begin
        ptr_d = ptr_q;
        if (hs0 || hs1) ptr_d = other_req(gnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= GNT_REQ0;
        else        ptr_q <= ptr_d;
    end

    assign both_sel = ptr_q;
`else
    assign both_sel = GNT_REQ0;
`endif

    always_comb begin
        gnt = GNT_REQ0;
        if (req0_v && req1_v) gnt = both_sel;
        else if (req1_v)      gnt = GNT_REQ1;
    end

    assign req0_rdy = !stall && req0_v && (gnt == GNT_REQ0);
    assign req1_rdy = !stall && req1_v && (gnt == GNT_REQ1);
    assign hs0      = req0_rdy;
    assign hs1      = req1_rdy;

    always_comb begin
        sel_req.valid = hs0 || hs1;
        sel_req.addr  = (gnt == GNT_REQ1) ? req1_addr : req0_addr;
        sel_req.data  = (gnt == GNT_REQ1) ? req1_data : req0_data;
    end

    // An x0 transfer is consumed but never raises the write enable.
    always_comb begin
        wen3_d = sel_req.valid && (sel_req.addr != '0);
        a3_d   = sel_req.valid ? sel_req.addr : a3_q;
        wd3_d  = sel_req.valid ? sel_req.data : wd3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen3_q <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
        end else begin
            wen3_q <= wen3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
        end
    end

    assign wen3 = wen3_q;
    assign a3   = a3_q;
    assign wd3  = wd3_q;

    cpu_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .set_v_i     (iss_v),
        .set_addr_i  (iss_addr),
        .clr_v_i     (hs1),
        .clr_addr_i  (req1_addr),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .haz1_o      (haz1),
        .haz2_o      (haz2),
        .pend_mask_o (pend_mask)
    );

endmodule

// File: tb/tb_cpu_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_rf_wb_arbiter
// Directed scenarios plus randomized traffic for cpu_rf_wb_arbiter, checked
// against a transaction-level reference model (expected-write queue, pending
// bit vector, favoured-requester index).
// ----------------------------------------------------------------------------
module tb_cpu_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req0_v, req0_rdy, req1_v, req1_rdy;
    logic [AW-1:0] req0_addr, req1_addr, iss_addr, rs1, rs2, a3;
    logic [DW-1:0] req0_data, req1_data, wd3;
    logic          stall, iss_v, haz1, haz2, wen3;
    logic [31:0]   pend_mask;

    cpu_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_v    (req0_v),
        .req0_rdy  (req0_rdy),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_v    (req1_v),
        .req1_rdy  (req1_rdy),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .stall     (stall),
        .iss_v     (iss_v),
        .iss_addr  (iss_addr),
        .rs1       (rs1),
        .rs2       (rs2),
        .haz1      (haz1),
        .haz2      (haz2),
        .pend_mask (pend_mask),
        .wen3      (wen3),
        .a3        (a3),
        .wd3       (wd3)
    );

    // ---------------- scoreboard / model state ----------------
    logic [AW+DW-1:0] exp_q[$];   // writes expected on the bank port
    logic [31:0]      pend_m;     // registers with an outstanding load write
    int               favour;     // requester preferred when both are valid
    int               obs_gnt;    // requester the DUT granted this cycle
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        req0_v = 0; req0_addr = '0; req0_data = '0;
        req1_v = 0; req1_addr = '0; req1_data = '0;
        stall = 0; iss_v = 0; iss_addr = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_m = '0;
        favour = 0;
    endtask

    // Called at a falling edge with rst_n high or low; returns at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        check("rst_wen3", wen3, 0);
        check("rst_a3", a3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_pend", pend_mask, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Inputs are already driven at a falling edge. Checks the combinational
    // outputs, advances the model over one rising edge, checks registered
    // outputs, and returns at the next falling edge.
    task automatic run_cycle();
        int          g;
        logic [31:0] np;
        #1;
        g = -1;
        if (!stall) begin
            if (req0_v && req1_v) g = favour;
            else if (req0_v)      g = 0;
            else if (req1_v)      g = 1;
        end
        obs_gnt = req0_rdy ? 0 : (req1_rdy ? 1 : -1);
        check("req0_rdy", req0_rdy, g == 0);
        check("req1_rdy", req1_rdy, g == 1);
        check("haz1", haz1, (rs1 != 0) && pend_m[rs1]);
        check("haz2", haz2, (rs2 != 0) && pend_m[rs2]);

        np = pend_m;
        if (g == 0 && req0_addr != 0) exp_q.push_back({req0_addr, req0_data});
        if (g == 1) begin
            if (req1_addr != 0) exp_q.push_back({req1_addr, req1_data});
            np[req1_addr] = 1'b0;
        end
        if (iss_v && iss_addr != 0) np[iss_addr] = 1'b1;
`ifdef CPU_RF_WB_ARB_RR_EN
        if (g == 0) favour = 1;
        if (g == 1) favour = 0;
`endif

        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [AW+DW-1:0] w;
            w = exp_q.pop_front();
            check("wen3", wen3, 1);
            check("a3_wd3", {a3, wd3}, w);
        end else begin
            check("wen3", wen3, 0);
        end
        check("pend_mask", pend_mask, np);
        pend_m = np;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int exp_g[4];

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Single execute-pipe write, first edge after reset release.
        req0_v = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
        run_cycle();
        check("d035_wen3", wen3, 1);
        check("d035_a3", a3, 5);
        check("d035_wd3", wd3, 32'hDEADBEEF);
        idle();
        run_cycle();

        // Both requesters valid for four cycles, back-to-back writes.
        do_reset();
`ifdef CPU_RF_WB_ARB_RR_EN
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            req0_v = 1; req0_addr = AW'(i + 1);  req0_data = 32'h1000 + i;
            req1_v = 1; req1_addr = AW'(i + 11); req1_data = 32'h2000 + i;
            run_cycle();
            check("d036_gnt", obs_gnt, exp_g[i]);
            check("d036_wen3", wen3, 1);
        end
        idle();
        run_cycle();

        // Write to x0 is consumed without a bank write.
        req1_v = 1; req1_addr = 0; req1_data = 32'h1234;
        run_cycle();
        check("d037_wen3", wen3, 0);
        idle();
        run_cycle();

        // Pending hazard set by issue, cleared by the load write.
        iss_v = 1; iss_addr = 7; rs1 = 7;
        run_cycle();
        check("d038_haz1_set", haz1, 1);
        iss_v = 0; req1_v = 1; req1_addr = 7; req1_data = 32'hCAFE0007;
        run_cycle();
        check("d038_haz1_clr", haz1, 0);
        idle();
        run_cycle();

        // Same-cycle set and clear of register 9 leaves it pending.
        iss_v = 1; iss_addr = 9;
        run_cycle();
        req1_v = 1; req1_addr = 9; req1_data = 32'h99;
        run_cycle();
        check("d039_pend9", pend_mask[9], 1);
        idle();
        run_cycle();

        // Stall blocks both requesters.
        stall = 1; req0_v = 1; req0_addr = 3; req1_v = 1; req1_addr = 4;
        run_cycle();
        check("d040_stall_wen3", wen3, 0);
        idle();
        run_cycle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            req0_v    = $urandom_range(0, 1);
            req0_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req0_data = $urandom;
            req1_v    = $urandom_range(0, 1);
            req1_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req1_data = $urandom;
            stall     = ($urandom_range(0, 4) == 0);
            iss_v     = $urandom_range(0, 1);
            iss_addr  = AW'($urandom);
            rs1       = AW'($urandom);
            rs2       = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
            run_cycle();
        end
        idle();
        run_cycle();

        // Reset right after a capture: write is dropped, mask cleared at once.
        iss_v = 1; iss_addr = 4;
        run_cycle();
        iss_v = 0;
        req0_v = 1; req0_addr = 3; req0_data = 32'hA5A5A5A5;
        #1;
        @(posedge clk);
        #1;
        check("d040_captured", wen3, 1);
        rst_n = 1'b0;
        #1;
        check("d040_rst_wen3", wen3, 0);
        check("d040_rst_pend", pend_mask, 0);
        check("d040_rst_a3", a3, 0);
        model_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        repeat (2) run_cycle();

        // Reset across the capturing edge: no pulse after release.
        req1_v = 1; req1_addr = 6; req1_data = 32'h66;
        rst_n = 1'b0;
        @(negedge clk);
        idle();
        model_reset();
        rst_n = 1'b1;
        repeat (2) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_rf_wb_arbiter.md
CPU_RF_WB_ARBITER -- requirements
Module: cpu_rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_v / req0_rdy  input / output  1 / 1  execute-pipe write request valid / ready.
REQ-006 req0_addr / req0_data  input  ADDR_WIDTH / DATA_WIDTH  execute-pipe destination address / data.
REQ-007 req1_v / req1_rdy  input / output  1 / 1  load/multicycle-unit write request valid / ready.
REQ-008 req1_addr / req1_data  input  ADDR_WIDTH / DATA_WIDTH  load-unit destination address / data.
REQ-009 stall  input  1  blocks all grants while high.
REQ-010 iss_v / iss_addr  input  1 / ADDR_WIDTH  load-unit issue marking its destination pending.
REQ-011 rs1 / rs2  input  ADDR_WIDTH / ADDR_WIDTH  read addresses to check against pending writes.
REQ-012 haz1 / haz2  output  1 / 1  pending-write hazard on rs1 / rs2.
REQ-013 pend_mask  output  2**ADDR_WIDTH  one bit per register with an outstanding load-unit write.
REQ-014 wen3 / a3 / wd3  output  1 / ADDR_WIDTH / DATA_WIDTH  registered register-bank write port.

Function
REQ-015 Handshake on requester i SHALL occur in a cycle where reqi_v and reqi_rdy are both 1; at most one handshake per cycle.
REQ-016 reqi_rdy SHALL be combinational: 1 only when stall=0, reqi_v=1 and requester i holds the grant.
REQ-017 Only one requester valid SHALL give it the grant; both valid SHALL grant the requester favoured by the priority pointer.
REQ-018 After a handshake on requester i the pointer SHALL favour the other requester; with no handshake it SHALL hold.
REQ-019 The cycle after a handshake, wen3=1 for exactly one cycle with a3/wd3 equal to the captured addr/data; latency 1.
REQ-020 A handshake with addr=0 SHALL be consumed but produce wen3=0 the next cycle (x0 never written).
REQ-021 With no handshake, wen3 SHALL be 0 next cycle; a3/wd3 hold their last values.
REQ-022 stall=1 SHALL force both rdy to 0, wen3 to 0 next cycle, and leave pointer and pend_mask write-side clears unchanged.
REQ-023 iss_v=1 with iss_addr!=0 SHALL set pend_mask[iss_addr] next cycle; iss_addr=0 ignored.
REQ-024 A req1 handshake SHALL clear pend_mask[req1_addr] next cycle; req0 handshakes SHALL never clear bits.
REQ-025 Same-cycle set and clear of the same bit SHALL leave it set; of different bits both SHALL apply.
REQ-026 haz1 = pend_mask[rs1], haz2 = pend_mask[rs2], combinational; rs=0 always gives 0.
REQ-027 Back-to-back handshakes SHALL produce back-to-back wen3 pulses without bubbles.

Reset
REQ-028 rst_n low SHALL immediately force wen3=0, a3=0, wd3=0, pend_mask=0, pointer favouring requester 0.
REQ-029 Reset mid-transaction SHALL discard the captured write; no wen3 pulse after release.
REQ-030 First grant is possible in the first rising edge with rst_n high.

Configuration
REQ-031 Macro CPU_RF_WB_ARB_RR_EN defined: round-robin per REQ-017/018.
REQ-032 Macro undefined: fixed priority, requester 0 always wins when both valid; pointer logic absent.

Structure
REQ-033 Grant-select enum and a write-request struct (valid, addr, data) SHALL live in pkg_cpu_typedefs.
REQ-034 Pending tracking SHALL be one sub-module cpu_rf_scoreboard (set/clear/lookup, pend_mask).

Verification
REQ-035 req0_v=1 addr=5 data=0xDEADBEEF alone -> req0_rdy=1; next cycle wen3=1 a3=5 wd3=0xDEADBEEF.
REQ-036 Both valid for 4 cycles (RR_EN) -> grants 0,1,0,1; fixed build -> 0,0,0,0 with req1_rdy=0.
REQ-037 req1 addr=0 data=0x1234 -> consumed, wen3 stays 0; no write reaches the bank.
REQ-038 iss_v addr=7, rs1=7 -> haz1=1 from next cycle; req1 handshake addr=7 -> haz1=0 one cycle later.
REQ-039 iss_v addr=9 same cycle as req1 handshake addr=9 -> pend_mask[9]=1 afterward.
REQ-040 stall=1 with both valid -> both rdy=0, wen3=0; rst_n low mid-capture -> wen3=0, pend_mask=0 immediately.
